alu_ex_stage: RTL and testbench
===============================

Name: alu_ex_stage

Overview:
Two-register execute stage wrapped around the team's combinational 32-bit ALU. It accepts a decoded operand bundle with a valid/ready handshake and registers it (S1). It drives the ALU's operation/A/B inputs from S1, then captures the ALU's res/zero/overflow together with the writeback and branch metadata into a result register (S2). S2 feeds writeback/branch resolution through a second valid/ready handshake.

Parameters:
DATA_W, 32, operand/result width; must match ALU width.
RD_W, 5, destination register index width.
CNT_W, 16, width of saturating overflow event counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous kill of all in-flight entries.
in_valid  input  1  upstream bundle valid.
in_ready  output  1  stage can accept this cycle.
in_op  input  3  ALU operation code (000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt).
in_a  input  DATA_W  operand A.
in_b  input  DATA_W  operand B.
in_rd  input  RD_W  destination register.
in_br  input  2  branch type: 00 none, 01 beq, 10 bne, 11 reserved (treated as none).
alu_op  output  3  to ALU ALU_operation.
alu_a  output  DATA_W  to ALU A.
alu_b  output  DATA_W  to ALU B.
alu_res  input  DATA_W  from ALU res.
alu_zero  input  1  from ALU zero.
alu_ovf  input  1  from ALU overflow.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts.
out_res  output  DATA_W  registered ALU result.
out_rd  output  RD_W  registered destination.
out_wen  output  1  register write enable.
out_taken  output  1  branch taken.
out_ovf  output  1  arithmetic overflow on this result.
ovf_cnt  output  CNT_W  count of overflow results delivered.

Behaviour:
- Reset (rst_n low, async): S1/S2 valid = 0; out_res, out_rd, alu_a, alu_b = 0; alu_op = 000; out_wen/out_taken/out_ovf = 0; ovf_cnt = 0.
- S1 holds op/a/b/rd/br. alu_op/alu_a/alu_b are driven straight from S1 registers, with no combinational path from in_*.
- s2_adv = s1_valid && (!s2_valid || out_ready). in_ready = !s1_valid || s2_adv. in_ready depends only on state and out_ready.
- S1 load: in_valid && in_ready. S1 clears when s2_adv && !(in_valid && in_ready).
- S2 load on s2_adv:
  - out_res = alu_res.
  - out_rd = s1_rd.
  - out_ovf = alu_ovf && (s1_op==010 || s1_op==110).
  - out_taken = (br==01 && alu_zero) || (br==10 && !alu_zero).
  - out_wen = (s1_rd != 0) && (br==00 || br==11) && !out_ovf.
- S2 clears when out_valid && out_ready && !s2_adv.
- Latency: accept at edge N, out_valid high after edge N+1. Throughput is 1 bundle/cycle with out_ready held high.
- Backpressure: out_ready low holds all S2 outputs stable. S1 fills once, then in_ready = 0.
- Simultaneous accept, advance and drain in one cycle is legal. No bundle is lost or duplicated.
- flush (synchronous) clears S1/S2 valid; it overrides a same-cycle accept. Data registers may keep stale values. ovf_cnt is not cleared by flush.
- ovf_cnt increments on each out_valid && out_ready && out_ovf handshake. It saturates at all-ones.
- rst_n asserted mid-operation discards both entries immediately, without waiting for a clock edge.
- Branch bundles rely on upstream issuing sub (110). The stage does not check the op code.

Test Plan:
- Single add: in_op=010, a=3, b=4, rd=5 -> two cycles later out_res=7, out_wen=1, out_ovf=0, out_taken=0.
- Overflow: add a=0x7FFFFFFF, b=1, rd=8 -> out_ovf=1, out_wen=0, ovf_cnt 0->1 on handshake. Same operands with op=011 (xor) -> out_ovf=0.
- Branch: sub a=5, b=5, br=01 -> out_taken=1, out_wen=0. Then br=10 with a=5, b=6 -> out_taken=1. br=01 with a=5, b=6 -> out_taken=0.
- Backpressure: stream 4 bundles (rd=1..4) with out_ready low for 3 cycles -> in_ready drops after 2 accepts. Outputs arrive in order 1,2,3,4 with no loss or duplication, and S2 outputs stay stable while stalled.
- Flush: two bundles in flight, flush=1 for 1 cycle with in_valid=1 -> out_valid=0 next cycle, the concurrent bundle is dropped, ovf_cnt unchanged.
- Async reset: drop rst_n between clock edges while both stages are full -> out_valid, in-stage state and ovf_cnt go to 0 immediately. in_ready=1 after release.

Source files
------------

// File: rtl/alu_ex_stage_if.sv
// alu_ex_stage_if: upstream bundle, ALU hookup and downstream result signals of the execute stage.
interface alu_ex_stage_if #(
   parameter int DATA_W = 32,
   parameter int RD_W = 5,
   parameter int CNT_W = 16
);
   logic in_valid;
   logic in_ready;
   logic [2:0] in_op;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic [RD_W-1:0] in_rd;
   logic [1:0] in_br;
   logic [2:0] alu_op;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_res;
   logic alu_zero;
   logic alu_ovf;
   logic out_valid;
   logic out_ready;
   logic [DATA_W-1:0] out_res;
   logic [RD_W-1:0] out_rd;
   logic out_wen;
   logic out_taken;
   logic out_ovf;
   logic [CNT_W-1:0] ovf_cnt;
   modport slave (
      input in_valid, in_op, in_a, in_b, in_rd, in_br, alu_res, alu_zero, alu_ovf, out_ready,
      output in_ready, alu_op, alu_a, alu_b, out_valid, out_res, out_rd, out_wen, out_taken, out_ovf, ovf_cnt
   );
   modport master (
      output in_valid, in_op, in_a, in_b, in_rd, in_br, alu_res, alu_zero, alu_ovf, out_ready,
      input in_ready, alu_op, alu_a, alu_b, out_valid, out_res, out_rd, out_wen, out_taken, out_ovf, ovf_cnt
   );
endinterface

// File: rtl/alu_ex_stage.sv
// alu_ex_stage: two-register execute stage; S1 feeds an external ALU, S2 captures result plus writeback/branch info.
module alu_ex_stage #(
   parameter int DATA_W = 32,
   parameter int RD_W = 5,
   parameter int CNT_W = 16
) (
   input logic clk,
   input logic rst_n,
   input logic flush,
   alu_ex_stage_if.slave bus
);
   logic s1_valid;
   logic [2:0] s1_op;
   logic [DATA_W-1:0] s1_a;
   logic [DATA_W-1:0] s1_b;
   logic [RD_W-1:0] s1_rd;
   logic [1:0] s1_br;
   logic s2_valid;
   logic [DATA_W-1:0] s2_res;
   logic [RD_W-1:0] s2_rd;
   logic s2_wen;
   logic s2_taken;
   logic s2_ovf;
   logic [CNT_W-1:0] cnt;
   logic s2_adv;
   logic acc;
   logic drain;
   logic ovf_n;
   logic taken_n;
   logic wen_n;
   assign s2_adv = s1_valid && (!s2_valid || bus.out_ready);
   assign bus.in_ready = !s1_valid || s2_adv;
   assign acc = bus.in_valid && bus.in_ready;
   assign drain = s2_valid && bus.out_ready;
   // only add/sub overflow is architectural; the ALU flag is meaningless for other ops
   assign ovf_n = bus.alu_ovf && (s1_op == 3'b010 || s1_op == 3'b110);
   assign taken_n = (s1_br == 2'b01 && bus.alu_zero) || (s1_br == 2'b10 && !bus.alu_zero);
   assign wen_n = (s1_rd != '0) && (s1_br == 2'b00 || s1_br == 2'b11) && !ovf_n;
   assign bus.alu_op = s1_op;
   assign bus.alu_a = s1_a;
   assign bus.alu_b = s1_b;
   assign bus.out_valid = s2_valid;
   assign bus.out_res = s2_res;
   assign bus.out_rd = s2_rd;
   assign bus.out_wen = s2_wen;
   assign bus.out_taken = s2_taken;
   assign bus.out_ovf = s2_ovf;
   assign bus.ovf_cnt = cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op <= 3'b000;
         s1_a <= '0;
         s1_b <= '0;
         s1_rd <= '0;
         s1_br <= 2'b00;
      end else begin
         s1_valid <= flush ? 1'b0 : acc ? 1'b1 : s2_adv ? 1'b0 : s1_valid;
         if (acc) begin
            s1_op <= bus.in_op;
            s1_a <= bus.in_a;
            s1_b <= bus.in_b;
            s1_rd <= bus.in_rd;
            s1_br <= bus.in_br;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_res <= '0;
         s2_rd <= '0;
         s2_wen <= 1'b0;
         s2_taken <= 1'b0;
         s2_ovf <= 1'b0;
      end else begin
         s2_valid <= flush ? 1'b0 : s2_adv ? 1'b1 : drain ? 1'b0 : s2_valid;
         if (s2_adv) begin
            s2_res <= bus.alu_res;
            s2_rd <= s1_rd;
            s2_wen <= wen_n;
            s2_taken <= taken_n;
            s2_ovf <= ovf_n;
         end
      end
   end
   // delivered-overflow counter survives flush; saturates rather than wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (drain && s2_ovf && !(&cnt)) cnt <= cnt + 1'b1;
   end
endmodule

// File: tb/tb_alu_ex_stage.sv
// tb_alu_ex_stage: behavioural ALU around the stage, scoreboard of expected results, scenario tasks.
module tb_alu_ex_stage;
   localparam int DW = 32;
   localparam int RW = 5;
   localparam int CW = 4;
   typedef struct packed {
      logic [DW-1:0] res;
      logic [RW-1:0] rd;
      logic wen;
      logic taken;
      logic ovf;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;
   exp_t q[$];
   exp_t e_pop;
   exp_t got;
   always #5 clk = ~clk;
   alu_ex_stage_if #(.DATA_W(DW), .RD_W(RW), .CNT_W(CW)) bus ();
   alu_ex_stage #(.DATA_W(DW), .RD_W(RW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
   // adder-based ALU: the overflow flag comes from the adder regardless of op
   function automatic logic [DW+1:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] s;
      logic [DW-1:0] d;
      logic [DW-1:0] r;
      logic v;
      s = a + b;
      d = a - b;
      case (op)
         3'b000: r = a & b;
         3'b001: r = a | b;
         3'b010: r = s;
         3'b011: r = a ^ b;
         3'b100: r = ~(a | b);
         3'b101: r = a >> b[4:0];
         3'b110: r = d;
         default: r = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
      endcase
      v = (op == 3'b110 || op == 3'b111) ? (a[DW-1] != b[DW-1] && d[DW-1] != a[DW-1])
                                         : (a[DW-1] == b[DW-1] && s[DW-1] != a[DW-1]);
      return {v, r == '0, r};
   endfunction
   function automatic exp_t model(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic [RW-1:0] rd, input logic [1:0] br);
      logic [DW+1:0] r;
      exp_t e;
      r = alu_f(op, a, b);
      e.res = r[DW-1:0];
      e.rd = rd;
      e.ovf = r[DW+1] && (op == 3'b010 || op == 3'b110);
      e.taken = (br == 2'b01 && r[DW]) || (br == 2'b10 && !r[DW]);
      e.wen = rd != 0 && (br == 2'b00 || br == 2'b11) && !e.ovf;
      return e;
   endfunction
   always_comb {bus.alu_ovf, bus.alu_zero, bus.alu_res} = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
   // scoreboard: inputs and outputs are stable at the falling edge, so handshakes are observed there
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            got = '{bus.out_res, bus.out_rd, bus.out_wen, bus.out_taken, bus.out_ovf};
            if (q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got rd=%0d res=%h with nothing pending", bus.out_rd, bus.out_res);
            end else begin
               e_pop = q.pop_front();
               if (got !== e_pop) begin
                  errors++;
                  $display("FAIL sb_result: got res=%h rd=%0d wen=%0b tk=%0b ovf=%0b exp res=%h rd=%0d wen=%0b tk=%0b ovf=%0b",
                           got.res, got.rd, got.wen, got.taken, got.ovf, e_pop.res, e_pop.rd, e_pop.wen, e_pop.taken, e_pop.ovf);
               end
               if (e_pop.ovf && exp_cnt < (1 << CW) - 1) exp_cnt++;
            end
         end
         if (flush) q.delete();
         else if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_op, bus.in_a, bus.in_b, bus.in_rd, bus.in_br));
      end
   end
   always @(negedge rst_n) begin
      q.delete();
      exp_cnt = 0;
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [RW-1:0] rd, input logic [1:0] br);
      logic ok;
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_op = op;
      bus.in_a = a;
      bus.in_b = b;
      bus.in_rd = rd;
      bus.in_br = br;
      do begin
         @(negedge clk);
         ok = bus.in_ready;
         tick();
         n++;
      end while (!ok && n < 50);
      bus.in_valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", n);
      end
   endtask
   task automatic wait_empty();
      int n;
      n = 0;
      bus.out_ready = 1'b1;
      while ((bus.out_valid || q.size() != 0) && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL drain_timeout: out_valid=%0b pending=%0d, required empty", bus.out_valid, q.size());
      end
   endtask
   task automatic test_reset();
      #12;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.alu_op, bus.alu_a, bus.out_res, bus.out_wen, bus.ovf_cnt} !==
          {1'b0, 1'b1, 3'b000, 32'd0, 32'd0, 1'b0, 4'd0}) begin
         errors++;
         $display("FAIL reset_state: ov=%0b ir=%0b op=%0d a=%h res=%h wen=%0b cnt=%0d", bus.out_valid, bus.in_ready,
                  bus.alu_op, bus.alu_a, bus.out_res, bus.out_wen, bus.ovf_cnt);
      end
      rst_n = 1'b1;
      tick();
   endtask
   task automatic test_single_add();
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_op = 3'b010;
      bus.in_a = 32'd3;
      bus.in_b = 32'd4;
      bus.in_rd = 5'd5;
      bus.in_br = 2'b00;
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.alu_a !== 32'd3) begin
         errors++;
         $display("FAIL add_latency1: out_valid=%0b alu_a=%0d, required 0 and 3", bus.out_valid, bus.alu_a);
      end
      tick();
      checks++;
      if ({bus.out_valid, bus.out_res, bus.out_wen, bus.out_ovf, bus.out_taken} !== {1'b1, 32'd7, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL add_result: ov=%0b res=%0d wen=%0b ovf=%0b tk=%0b, required 1 7 1 0 0",
                  bus.out_valid, bus.out_res, bus.out_wen, bus.out_ovf, bus.out_taken);
      end
      wait_empty();
   endtask
   task automatic test_overflow();
      bus.out_ready = 1'b0;
      send(3'b010, 32'h7FFF_FFFF, 32'd1, 5'd8, 2'b00);
      tick();
      checks++;
      if ({bus.out_valid, bus.out_ovf, bus.out_wen, bus.ovf_cnt} !== {1'b1, 1'b1, 1'b0, 4'd0}) begin
         errors++;
         $display("FAIL ovf_held: ov=%0b ovf=%0b wen=%0b cnt=%0d, required 1 1 0 0", bus.out_valid, bus.out_ovf,
                  bus.out_wen, bus.ovf_cnt);
      end
      bus.out_ready = 1'b1;
      tick();
      checks++;
      if (bus.ovf_cnt !== 4'd1) begin
         errors++;
         $display("FAIL ovf_count: cnt=%0d, required 1", bus.ovf_cnt);
      end
      send(3'b011, 32'h7FFF_FFFF, 32'd1, 5'd8, 2'b00);
      wait_empty();
      checks++;
      if (bus.ovf_cnt !== 4'd1) begin
         errors++;
         $display("FAIL xor_no_ovf_count: cnt=%0d, required 1", bus.ovf_cnt);
      end
   endtask
   task automatic test_branch();
      logic [1:0] brs[3] = '{2'b01, 2'b10, 2'b01};
      logic [DW-1:0] bs[3] = '{32'd5, 32'd6, 32'd6};
      logic exp_tk[3] = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         bus.out_ready = 1'b0;
         send(3'b110, 32'd5, bs[i], 5'd3, brs[i]);
         tick();
         checks++;
         if ({bus.out_valid, bus.out_taken, bus.out_wen} !== {1'b1, exp_tk[i], 1'b0}) begin
            errors++;
            $display("FAIL branch_%0d: ov=%0b tk=%0b wen=%0b, required 1 %0b 0", i, bus.out_valid, bus.out_taken,
                     bus.out_wen, exp_tk[i]);
         end
         wait_empty();
      end
   endtask
   task automatic test_backpressure();
      int idx;
      logic acc;
      idx = 0;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 30 && idx < 4; c++) begin
         bus.out_ready = c >= 3;
         bus.in_op = 3'b010;
         bus.in_a = 32'(10 * (idx + 1));
         bus.in_b = 32'd1;
         bus.in_rd = 5'(idx + 1);
         bus.in_br = 2'b00;
         @(negedge clk);
         if (c == 2 || c == 3) begin
            checks++;
            if ({bus.out_valid, bus.out_rd, bus.out_res} !== {1'b1, 5'd1, 32'd11} || (c == 2 && (bus.in_ready !== 1'b0 || idx != 2))) begin
               errors++;
               $display("FAIL bp_stall_c%0d: ov=%0b rd=%0d res=%0d ir=%0b accepted=%0d, required 1 1 11 ir0 2", c,
                        bus.out_valid, bus.out_rd, bus.out_res, bus.in_ready, idx);
            end
         end
         acc = bus.in_ready;
         tick();
         if (acc) idx++;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (idx != 4) begin
         errors++;
         $display("FAIL bp_accepts: accepted %0d, required 4", idx);
      end
      wait_empty();
   endtask
   task automatic test_flush();
      int cnt0;
      cnt0 = exp_cnt;
      bus.out_ready = 1'b0;
      send(3'b010, 32'h7FFF_FFFF, 32'd1, 5'd9, 2'b00);
      send(3'b010, 32'h7FFF_FFFF, 32'd2, 5'd10, 2'b00);
      bus.in_valid = 1'b1;
      bus.in_rd = 5'd11;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_clear: ov=%0b ir=%0b, required 0 1", bus.out_valid, bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_rd = 5'd12;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.ovf_cnt !== 4'(cnt0)) begin
         errors++;
         $display("FAIL flush_drop: ov=%0b cnt=%0d, required 0 %0d", bus.out_valid, bus.ovf_cnt, cnt0);
      end
      wait_empty();
   endtask
   task automatic test_back_to_back();
      int n;
      logic acc;
      n = 0;
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.in_op = 3'($urandom_range(0, 7));
         bus.in_a = $urandom;
         bus.in_b = $urandom;
         bus.in_rd = 5'($urandom);
         bus.in_br = 2'($urandom);
         @(negedge clk);
         acc = bus.in_ready;
         tick();
         if (acc) n++;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (n != 8) begin
         errors++;
         $display("FAIL b2b_throughput: accepted %0d of 8 cycles, required 8", n);
      end
      wait_empty();
   endtask
   task automatic test_saturation();
      logic acc;
      int n;
      n = 0;
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_op = 3'b110;
      bus.in_a = 32'h8000_0000;
      bus.in_b = 32'd1;
      bus.in_rd = 5'd7;
      bus.in_br = 2'b00;
      while (n < 20) begin
         @(negedge clk);
         acc = bus.in_ready;
         tick();
         if (acc) n++;
      end
      bus.in_valid = 1'b0;
      wait_empty();
      checks++;
      if (bus.ovf_cnt !== 4'hF) begin
         errors++;
         $display("FAIL ovf_saturate: cnt=%0d, required 15", bus.ovf_cnt);
      end
   endtask
   task automatic test_async_reset();
      bus.out_ready = 1'b0;
      send(3'b001, 32'hF0, 32'h0F, 5'd4, 2'b00);
      send(3'b000, 32'hF0, 32'h3C, 5'd6, 2'b00);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.ovf_cnt, bus.alu_a, bus.out_res} !== {1'b0, 1'b1, 4'd0, 32'd0, 32'd0}) begin
         errors++;
         $display("FAIL async_reset: ov=%0b ir=%0b cnt=%0d alu_a=%h res=%h, required 0 1 0 0 0", bus.out_valid,
                  bus.in_ready, bus.ovf_cnt, bus.alu_a, bus.out_res);
      end
      #2;
      rst_n = 1'b1;
      tick();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: ir=%0b ov=%0b, required 1 0", bus.in_ready, bus.out_valid);
      end
      send(3'b101, 32'h100, 32'd4, 5'd2, 2'b11);
      wait_empty();
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.in_op = 3'b000;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.in_rd = '0;
      bus.in_br = 2'b00;
      bus.out_ready = 1'b1;
      test_reset();
      test_single_add();
      test_overflow();
      test_branch();
      test_backpressure();
      test_flush();
      test_back_to_back();
      test_saturation();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
